uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type and bit-period helper.
// UART_RX_PARITY_EN adds the PARITY state used by uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } uart_rx_state_t;

    function automatic int unsigned ticks_per_bit(input int unsigned clock_freq,
                                                  input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with selectable reset value.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WIDTH data bits LSB-first, optional even parity, one stop bit.
// Define UART_RX_PARITY_EN to expect and check an even-parity bit after the data.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned WIDTH      = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             frame_error,
    output logic             overrun,
    output logic             parity_error
);

    localparam int unsigned TPB = ticks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = $clog2(TPB) + 1;
    localparam int unsigned BW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] TPB_C  = CW'(TPB);
    localparam logic [CW-1:0] HALF_C = CW'(TPB / 2);
    localparam logic [BW-1:0] LAST_C = BW'(WIDTH - 1);

    if (TPB < 4) begin : g_tpb_check
        $error("uart_rx: CLOCK_FREQ/BAUD_RATE must be at least 4");
    end

    logic w_rx;

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clock (clock),
        .resetn(resetn),
        .i_d   (rx),
        .o_q   (w_rx)
    );

    uart_rx_state_t   r_state, w_state_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [BW-1:0]    r_idx, w_idx_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [WIDTH-1:0] r_data, w_data_next;
    logic             r_valid, w_valid_next;
    logic             r_frame_error, w_frame_error_next;
    logic             r_overrun, w_overrun_next;
    logic             r_parity_error, w_parity_error_next;
    logic             r_par_bad, w_par_bad_next;
    logic             w_expire;

    // Counter runs down to 1, so a reload of TPB gives exactly TPB cycles between samples.
    assign w_expire = (r_cnt <= CW'(1));

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
        w_idx_next          = r_idx;
        w_shift_next        = r_shift;
        w_data_next         = r_data;
        w_valid_next        = r_valid && !ready;
        w_frame_error_next  = 1'b0;
        w_overrun_next      = 1'b0;
        w_parity_error_next = 1'b0;
        w_par_bad_next      = r_par_bad;

        unique case (r_state)
            StIdle: begin
                if (!w_rx) begin
                    w_cnt_next     = HALF_C;
                    w_par_bad_next = 1'b0;
                    w_state_next   = StStart;
                end
            end
            StStart: begin
                if (w_expire) begin
                    if (!w_rx) begin
                        w_cnt_next   = TPB_C;
                        w_idx_next   = '0;
                        w_state_next = StData;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            StData: begin
                if (w_expire) begin
                    // Shifting in from the top leaves the first received bit at index 0.
                    w_shift_next = {w_rx, r_shift[WIDTH-1:1]};
                    w_cnt_next   = TPB_C;
                    w_idx_next   = r_idx + 1'b1;
                    if (r_idx == LAST_C) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = StParity;
`else
                        w_state_next = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (w_expire) begin
                    if ((^r_shift) ^ w_rx) begin
                        w_parity_error_next = 1'b1;
                        w_par_bad_next      = 1'b1;
                    end
                    w_cnt_next   = TPB_C;
                    w_state_next = StStop;
                end
            end
`endif
            StStop: begin
                if (w_expire) begin
                    if (w_rx) begin
                        w_state_next = StIdle;
                        if (!r_par_bad) begin
                            if (r_valid && !ready) begin
                                w_overrun_next = 1'b1;
                            end else begin
                                w_data_next  = r_shift;
                                w_valid_next = 1'b1;
                            end
                        end
                    end else begin
                        w_frame_error_next = 1'b1;
                        w_state_next       = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (w_rx) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_shift        <= '0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
            r_parity_error <= 1'b0;
            r_par_bad      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_idx          <= w_idx_next;
            r_shift        <= w_shift_next;
            r_data         <= w_data_next;
            r_valid        <= w_valid_next;
            r_frame_error  <= w_frame_error_next;
            r_overrun      <= w_overrun_next;
            r_parity_error <= w_parity_error_next;
            r_par_bad      <= w_par_bad_next;
        end
    end

    assign data         = r_data;
    assign valid        = r_valid;
    assign frame_error  = r_frame_error;
    assign overrun      = r_overrun;
    assign parity_error = r_parity_error;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 1 MHz / 100 kbit/s (10 clocks per bit), 8 data bits.
module tb_uart_rx;

    localparam int TPB = 10;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 108;
`else
    localparam int LAT = 98;
`endif

    logic       clock;
    logic       resetn;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vhi_cnt = 0;
    int fe0, ov0, pe0, vhi0;
    int lat;

    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .WIDTH     (8)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .parity_error(parity_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Observer: words accepted by the consumer and error pulses, sampled mid-cycle.
    always @(negedge clock) begin
        if (valid && ready) begin
            got_q.push_back(data);
            got_cyc_q.push_back(cyc);
        end
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
        if (parity_error === 1'b1) pe_cnt <= pe_cnt + 1;
        if (valid === 1'b1) vhi_cnt <= vhi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Behavioural transmitter: one bit per TPB clocks, line left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        tick(TPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(TPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^b;
        tick(TPB);
`endif
        rx = stop_bit;
        tick(TPB);
    endtask

    task automatic snap();
        fe0  = fe_cnt;
        ov0  = ov_cnt;
        pe0  = pe_cnt;
        vhi0 = vhi_cnt;
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check(tag, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"}, {24'd0, data}, 0);
        check({tag, "_valid"}, {31'd0, valid}, 0);
        check({tag, "_fe"}, {31'd0, frame_error}, 0);
        check({tag, "_ov"}, {31'd0, overrun}, 0);
        check({tag, "_pe"}, {31'd0, parity_error}, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        int         fe_exp;

        rx = 1'b1;
        ready = 1'b1;
        resetn = 1'b0;
        tick(3);
        check_outputs_zero("reset");
        resetn = 1'b1;
        tick(5);

        // Single frame, consumer always ready.
        snap();
        send_frame(8'hA5, 1'b1);
        tick(20);
        lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - fall_cyc : -1;
        check("latency_window", {31'd0, (lat >= LAT - 3 && lat <= LAT + 3)}, 1);
        check("a5_valid_cycles", vhi_cnt - vhi0, 1);
        check("a5_fe", fe_cnt - fe0, 0);
        check("a5_ov", ov_cnt - ov0, 0);
        check("a5_pe", pe_cnt - pe0, 0);
        exp_q.push_back(8'hA5);
        check_words("a5_word");

        // Short low glitch must not start a frame.
        snap();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(30);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_valid", vhi_cnt - vhi0, 0);
        check_words("glitch_word");

        // Break: stop bit low, line held low, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0);
        tick(50);
        rx = 1'b1;
        tick(20);
        send_frame(8'h81, 1'b1);
        tick(20);
        check("break_fe", fe_cnt - fe0, 1);
        exp_q.push_back(8'h81);
        check_words("break_word");

        // Overrun: second word arrives while first is still held.
        snap();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(20);
        check("ovr_held_data", {24'd0, data}, 32'h11);
        check("ovr_held_valid", {31'd0, valid}, 1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        ready = 1'b1;
        tick(3);
        check("ovr_valid_cleared", {31'd0, valid}, 0);
        exp_q.push_back(8'h11);
        check_words("ovr_word");

        // Asynchronous reset in the middle of bit 4 of 0xF0.
        snap();
        b = 8'hF0;
        rx = 1'b0;
        tick(TPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            tick(TPB);
        end
        rx = b[4];
        tick(5);
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        rx = 1'b1;
        tick(3);
        check_outputs_zero("inreset");
        resetn = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1);
        tick(20);
        check("midreset_fe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h5A);
        check_words("midreset_word");

        // Back-to-back frames with a single stop bit.
        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(20);
        check("b2b_errors", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        check_words("b2b_word");

        // Random frames, random gaps, occasional bad stop bit.
        snap();
        fe_exp = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, !bad);
            if (bad) begin
                fe_exp++;
                rx = 1'b1;
                tick(10);
            end else begin
                exp_q.push_back(b);
                if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
            end
        end
        tick(20);
        check("rand_fe", fe_cnt - fe0, fe_exp);
        check("rand_ov", ov_cnt - ov0, 0);
        check("rand_pe", pe_cnt - pe0, 0);
        check_words("rand_word");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
